// File: rtl/p405s_icu_pkg.sv
// Shared ICU datapath constants and sizing helpers.
package p405s_icu_pkg;

    localparam int unsigned ICU_DP_WIDTH     = 32;
    localparam int unsigned ICU_DP_DEPTH_MIN = 1;
    localparam int unsigned ICU_DP_DEPTH_MAX = 4;

    // Smallest CNT width able to hold 0..depth.
    function automatic int unsigned icu_dp_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/p405s_icu_dp_regstage.sv
// One elastic pipeline stage: data register plus valid bit with load and kill.
module p405s_icu_dp_regstage
    import p405s_icu_pkg::*;
#(
    parameter int unsigned      WIDTH     = ICU_DP_WIDTH,
    parameter logic [0:WIDTH-1] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             ld_i,
    input  logic             vld_i,
    input  logic [0:WIDTH-1] d_i,
    output logic [0:WIDTH-1] q_o,
    output logic             vld_o,
    output logic             vld_nxt_o
);

    logic [0:WIDTH-1] data_d, data_q;
    logic             vld_d, vld_q;

    // Data only moves with a valid token; flush kills validity but never touches data.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (ld_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = d_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o       = data_q;
    assign vld_o     = vld_q;
    assign vld_nxt_o = vld_d;

endmodule

// File: rtl/p405s_icu_dp_regpipe.sv
// DEPTH-stage elastic datapath register with valid/ready handshake, flush and occupancy count.
module p405s_icu_dp_regpipe
    import p405s_icu_pkg::*;
#(
    parameter int unsigned      WIDTH     = ICU_DP_WIDTH,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [0:WIDTH-1] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 3
) (
    input  logic             CB,
    input  logic             RESETN,
    input  logic [0:WIDTH-1] D,
    input  logic             E1,
    output logic             RDY_OUT,
    input  logic             FLUSH,
    output logic [0:WIDTH-1] L2,
    output logic             L2_VLD,
    input  logic             TAKE,
    output logic [CNT_W-1:0] CNT
);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] up_vld;
    logic [0:WIDTH-1] up_d  [DEPTH];
    logic [0:WIDTH-1] stg_q [DEPTH];
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // A stage can load if it is empty or its successor is moving this cycle.
    always_comb begin
        rdy[DEPTH] = TAKE;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !vld[i] | rdy[i+1];
        end
    end

    always_comb begin
        up_vld[0] = E1;
        up_d[0]   = D;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i] = vld[i-1];
            up_d[i]   = stg_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        p405s_icu_dp_regstage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i     (CB),
            .rst_ni    (RESETN),
            .flush_i   (FLUSH),
            .ld_i      (rdy[g]),
            .vld_i     (up_vld[g]),
            .d_i       (up_d[g]),
            .q_o       (stg_q[g]),
            .vld_o     (vld[g]),
            .vld_nxt_o (vld_nxt[g])
        );
    end

    // Counting next-state valids keeps CNT in lockstep with the stage valid flops.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(vld_nxt[i]);
        end
    end

    always_ff @(posedge CB or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign RDY_OUT = rdy[0];
    assign L2      = stg_q[DEPTH-1];
    assign L2_VLD  = vld[DEPTH-1];
    assign CNT     = cnt_q;

endmodule

// File: tb/tb_p405s_icu_dp_regpipe.sv
// Bench for p405s_icu_dp_regpipe: directed vectors on DEPTH=3/1 plus a random soak on DEPTH=1..4.
module tb_p405s_icu_dp_regpipe;

    typedef struct {
        logic        e1;
        logic [31:0] d;
        logic        take;
        logic        flush;
        logic        exp_rdy;
        logic [31:0] exp_l2;
        logic        exp_vld;
        int          exp_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [0:31] d     [4];
    logic        e1    [4];
    logic        flush [4];
    logic        take  [4];
    logic        rdy   [4];
    logic [0:31] l2    [4];
    logic        l2_vld[4];
    logic [2:0]  cnt   [4];

    int checks;
    int errors;

    // Reference model: ordered list of tokens with their stage position, oldest first.
    logic [31:0] m_dat [4][4];
    int          m_pos [4][4];
    int          m_n   [4];
    logic [31:0] m_l2  [4];

    vec_t tbl [25];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        p405s_icu_dp_regpipe #(
            .WIDTH     (32),
            .DEPTH     (g + 1),
            .RESET_VAL ('0),
            .CNT_W     (3)
        ) u_dut (
            .CB      (clk),
            .RESETN  (rst_n),
            .D       (d[g]),
            .E1      (e1[g]),
            .RDY_OUT (rdy[g]),
            .FLUSH   (flush[g]),
            .L2      (l2[g]),
            .L2_VLD  (l2_vld[g]),
            .TAKE    (take[g]),
            .CNT     (cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", name, g, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ie1, input logic [31:0] id, input logic itake,
                                input logic iflush, input logic xrdy, input logic [31:0] xl2,
                                input logic xvld, input int xcnt);
        vec_t v;
        v.e1 = ie1; v.d = id; v.take = itake; v.flush = iflush;
        v.exp_rdy = xrdy; v.exp_l2 = xl2; v.exp_vld = xvld; v.exp_cnt = xcnt;
        return v;
    endfunction

    task automatic idle_all();
        for (int g = 0; g < 4; g++) begin
            d[g] = '0; e1[g] = 1'b0; flush[g] = 1'b0; take[g] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_n[g]  = 0;
            m_l2[g] = '0;
        end
    endtask

    task automatic model_step(input int g, input logic ie1, input logic [31:0] id,
                              input logic itake, input logic iflush);
        int   depth;
        int   lim;
        logic acc;
        depth = g + 1;
        if (iflush) begin
            m_n[g] = 0;
        end else begin
            acc = ie1 && ((m_n[g] < depth) || itake);
            if (m_n[g] > 0 && m_pos[g][0] == depth - 1 && itake) begin
                for (int k = 0; k < m_n[g] - 1; k++) begin
                    m_dat[g][k] = m_dat[g][k+1];
                    m_pos[g][k] = m_pos[g][k+1];
                end
                m_n[g]--;
            end
            // Each token advances one slot if the slot ahead is free after the move.
            lim = depth;
            for (int k = 0; k < m_n[g]; k++) begin
                if (m_pos[g][k] + 1 < lim) m_pos[g][k]++;
                lim = m_pos[g][k];
            end
            if (acc) begin
                m_dat[g][m_n[g]] = id;
                m_pos[g][m_n[g]] = 0;
                m_n[g]++;
            end
            if (m_n[g] > 0 && m_pos[g][0] == depth - 1) m_l2[g] = m_dat[g][0];
        end
    endtask

    initial begin
        logic        s_e1    [4];
        logic [31:0] s_d     [4];
        logic        s_take  [4];
        logic        s_flush [4];
        logic        mvld;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_all();
        model_reset();

        // Streaming through DEPTH=3 with TAKE=1.
        for (int n = 0; n < 6; n++) begin
            tbl[n] = mk(1, 32'hA000_0000 + n, 1, 0, 1, (n < 2) ? 32'h0 : 32'hA000_0000 + n - 2,
                        n >= 2, (n < 2) ? n + 1 : 3);
        end
        tbl[6]  = mk(0, 32'h0,         1, 0, 1, 32'hA000_0004, 1, 2);
        tbl[7]  = mk(0, 32'h0,         1, 0, 1, 32'hA000_0005, 1, 1);
        tbl[8]  = mk(0, 32'h0,         1, 0, 1, 32'hA000_0005, 0, 0);
        // Back-pressure, then zero-bubble drain.
        tbl[9]  = mk(1, 32'hDEAD_0001, 0, 0, 1, 32'hA000_0005, 0, 1);
        tbl[10] = mk(1, 32'hDEAD_0002, 0, 0, 1, 32'hA000_0005, 0, 2);
        tbl[11] = mk(1, 32'hDEAD_0003, 0, 0, 1, 32'hDEAD_0001, 1, 3);
        tbl[12] = mk(1, 32'hDEAD_0004, 0, 0, 0, 32'hDEAD_0001, 1, 3);
        tbl[13] = mk(1, 32'hDEAD_0004, 1, 0, 1, 32'hDEAD_0002, 1, 3);
        tbl[14] = mk(0, 32'h0,         1, 0, 1, 32'hDEAD_0003, 1, 2);
        tbl[15] = mk(0, 32'h0,         1, 0, 1, 32'hDEAD_0004, 1, 1);
        tbl[16] = mk(0, 32'h0,         1, 0, 1, 32'hDEAD_0004, 0, 0);
        // Flush at CNT=2 with a competing load that must be dropped.
        tbl[17] = mk(1, 32'hBEEF_0001, 0, 0, 1, 32'hDEAD_0004, 0, 1);
        tbl[18] = mk(1, 32'hBEEF_0002, 0, 0, 1, 32'hDEAD_0004, 0, 2);
        tbl[19] = mk(1, 32'hCAFE_F00D, 0, 1, 1, 32'hDEAD_0004, 0, 0);
        tbl[20] = mk(0, 32'h0,         1, 0, 1, 32'hDEAD_0004, 0, 0);
        tbl[21] = mk(1, 32'h0000_0055, 1, 0, 1, 32'hDEAD_0004, 0, 1);
        tbl[22] = mk(0, 32'h0,         1, 0, 1, 32'hDEAD_0004, 0, 1);
        tbl[23] = mk(0, 32'h0,         1, 0, 1, 32'h0000_0055, 1, 1);
        tbl[24] = mk(0, 32'h0,         1, 0, 1, 32'h0000_0055, 0, 0);

        #2;
        chk("rst_l2", 2, l2[2], 32'h0);
        chk("rst_vld", 2, {31'h0, l2_vld[2]}, 32'h0);
        chk("rst_cnt", 2, {29'h0, cnt[2]}, 32'h0);
        chk("rst_rdy", 2, {31'h0, rdy[2]}, 32'h1);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            e1[2] = tbl[i].e1; d[2] = tbl[i].d; take[2] = tbl[i].take; flush[2] = tbl[i].flush;
            #1;
            chk($sformatf("vec%0d_rdy", i), 2, {31'h0, rdy[2]}, {31'h0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("vec%0d_l2", i), 2, l2[2], tbl[i].exp_l2);
            chk($sformatf("vec%0d_vld", i), 2, {31'h0, l2_vld[2]}, {31'h0, tbl[i].exp_vld});
            chk($sformatf("vec%0d_cnt", i), 2, {29'h0, cnt[2]}, tbl[i].exp_cnt);
        end

        // Asynchronous reset with a full DEPTH=3 pipe, no clock edge in between.
        idle_all();
        for (int n = 1; n <= 3; n++) begin
            e1[2] = 1'b1; d[2] = 32'h1111_1111 * n;
            tick();
        end
        idle_all();
        chk("full_cnt", 2, {29'h0, cnt[2]}, 32'd3);
        chk("full_l2", 2, l2[2], 32'h1111_1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_l2", 2, l2[2], 32'h0);
        chk("async_rst_vld", 2, {31'h0, l2_vld[2]}, 32'h0);
        chk("async_rst_cnt", 2, {29'h0, cnt[2]}, 32'h0);
        chk("async_rst_rdy", 2, {31'h0, rdy[2]}, 32'h1);
        #2;
        rst_n = 1'b1;
        tick();

        // Legacy single-stage register behaviour.
        take[0] = 1'b1; e1[0] = 1'b1; d[0] = 32'h1234_5678;
        tick();
        chk("legacy_load_l2", 0, l2[0], 32'h1234_5678);
        chk("legacy_load_vld", 0, {31'h0, l2_vld[0]}, 32'h1);
        e1[0] = 1'b0; d[0] = 32'h9ABC_DEF0;
        tick();
        chk("legacy_hold_l2", 0, l2[0], 32'h1234_5678);
        chk("legacy_hold_vld", 0, {31'h0, l2_vld[0]}, 32'h0);
        idle_all();

        // Random soak on all depths against the token model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                model_reset();
            end
            for (int g = 0; g < 4; g++) begin
                s_e1[g]    = ($urandom_range(0, 9) < 6);
                s_take[g]  = ($urandom_range(0, 9) < 6);
                s_flush[g] = ($urandom_range(0, 19) == 0);
                s_d[g]     = $urandom;
                e1[g] = s_e1[g]; take[g] = s_take[g]; flush[g] = s_flush[g]; d[g] = s_d[g];
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                chk("soak_rdy", g, {31'h0, rdy[g]},
                    {31'h0, (m_n[g] < g + 1) || s_take[g]});
            end
            tick();
            for (int g = 0; g < 4; g++) begin
                model_step(g, s_e1[g], s_d[g], s_take[g], s_flush[g]);
                mvld = (m_n[g] > 0) && (m_pos[g][0] == g);
                chk("soak_l2", g, l2[g], m_l2[g]);
                chk("soak_vld", g, {31'h0, l2_vld[g]}, {31'h0, mvld});
                chk("soak_cnt", g, {29'h0, cnt[g]}, m_n[g]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
